// File: rtl/serial_word_add_driver_if.sv
// Bundle between the word-level driver, its operand producer/result consumer
// and the external bit-serial adder.
interface serial_word_add_driver_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             ser_clr;
  logic             ser_a;
  logic             ser_b;
  logic             ser_sum;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;

  // The driver block is the slave; the environment (producer, consumer,
  // serial adder) is the master.
  modport slave (
    input  in_valid, in_a, in_b, ser_sum, out_ready,
    output in_ready, ser_clr, ser_a, ser_b, out_valid, out_sum
  );

  modport master (
    output in_valid, in_a, in_b, ser_sum, out_ready,
    input  in_ready, ser_clr, ser_a, ser_b, out_valid, out_sum
  );
endinterface

// File: rtl/serial_word_add_driver.sv
// Parallel front end for the bit-serial adder: streams two operands LSB-first,
// collects WIDTH+1 sum bits (including the carry flush) and returns the word.
module serial_word_add_driver #(
  parameter int WIDTH = 8
) (
  input logic                     clk,
  input logic                     rst,
  serial_word_add_driver_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int             CW       = $clog2(WIDTH + 2);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_a_q, shift_b_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   result_q;
  logic             accept;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.ser_clr   = 1'b1;
    bus.ser_a     = 1'b0;
    bus.ser_b     = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Carry is only allowed to accumulate while bits are streaming.
        bus.ser_clr = 1'b0;
        bus.ser_a   = shift_a_q[0];
        bus.ser_b   = shift_b_q[0];
        if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the datapath registers are few and feed outputs directly, so they
  // take the async reset too; out_sum and ser_a/ser_b are then 0 during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_a_q <= '0;
      shift_b_q <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else if (accept) begin
      shift_a_q <= bus.in_a;
      shift_b_q <= bus.in_b;
      cnt_q     <= '0;
      result_q  <= '0;
    end else if (state_q == SHIFT) begin
      // Operands drain toward bit 0; the final cycle presents a=b=0, so the
      // returned bit is the adder carry and it lands in result_q[WIDTH].
      shift_a_q <= shift_a_q >> 1;
      shift_b_q <= shift_b_q >> 1;
      result_q  <= {bus.ser_sum, result_q[WIDTH:1]};
      cnt_q     <= cnt_q + 1'b1;
    end
  end

  assign bus.out_sum = result_q;

endmodule

// File: tb/tb_serial_word_add_driver.sv
// Self-checking bench: behavioural serial adder, table-driven vectors, a
// result scoreboard and hand-written multi-cycle sequences.
module tb_serial_word_add_driver;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_word_add_driver_if #(.WIDTH(W)) bus ();
  serial_word_add_driver_if #(.WIDTH(1)) bus1 ();

  serial_word_add_driver #(.WIDTH(W)) dut  (.clk(clk), .rst(rst), .bus(bus));
  serial_word_add_driver #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Bit-serial full adders with synchronous carry clear.
  logic carry, carry1;
  assign bus.ser_sum  = bus.ser_a ^ bus.ser_b ^ carry;
  assign bus1.ser_sum = bus1.ser_a ^ bus1.ser_b ^ carry1;
  always @(posedge clk) begin
    carry  <= bus.ser_clr ? 1'b0 :
              (bus.ser_a & bus.ser_b) | (bus.ser_a & carry) | (bus.ser_b & carry);
    carry1 <= bus1.ser_clr ? 1'b0 :
              (bus1.ser_a & bus1.ser_b) | (bus1.ser_a & carry1) | (bus1.ser_b & carry1);
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_out  = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected sums pushed on acceptance, popped on output handshake.
  logic [W:0] sb_q[$];
  int         acc_log[$];
  logic [W:0] sb_exp;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) begin
        sb_q.push_back({1'b0, bus.in_a} + {1'b0, bus.in_b});
        acc_log.push_back(cyc);
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_out: got 0x%0h with no pending operation", bus.out_sum);
        end else begin
          sb_exp = sb_q.pop_front();
          check("sb_out_sum", 32'(bus.out_sum), 32'(sb_exp));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation: wait for in_ready, accept, track latency and the ser_a stream.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W:0] exp, input string name);
    int         n;
    logic [W:0] sa;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    tick();
    bus.in_valid = 1'b0;
    bus.in_a     = W'($urandom);
    bus.in_b     = W'($urandom);
    n  = 0;
    sa = '0;
    while (!bus.out_valid && n < 30) begin
      if (n <= W) sa[n] = bus.ser_a;
      tick();
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'(W + 1));
    check({name, "_ser_a_seq"}, 32'(sa), 32'({1'b0, a}));
    check({name, "_out_sum"}, 32'(bus.out_sum), 32'(exp));
    if (bus.out_ready) begin
      tick();
      check({name, "_in_ready_after"}, 32'(bus.in_ready), 32'd1);
    end
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    while (!bus.out_valid && n < 30) begin
      tick();
      n++;
    end
    check({name, "_out_valid"}, 32'(bus.out_valid), 32'd1);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   sum;
  } vec_t;

  typedef struct {
    logic       a;
    logic       b;
    logic [1:0] sum;
  } vec1_t;

  vec_t         vecs[6];
  vec1_t        vecs1[2];
  logic [W-1:0] pa[4], pb[4];
  logic         acc;
  int           k, guard, n, out_base;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h5A, 8'h3C, 9'h096};
    vecs[1] = '{8'hFF, 8'h01, 9'h100};
    vecs[2] = '{8'hFF, 8'hFF, 9'h1FE};
    vecs[3] = '{8'h00, 8'h00, 9'h000};
    vecs[4] = '{8'h80, 8'h80, 9'h100};
    vecs[5] = '{8'h55, 8'hAA, 9'h0FF};
    vecs1[0] = '{1'b1, 1'b1, 2'b10};
    vecs1[1] = '{1'b1, 1'b0, 2'b01};

    bus.in_valid  = 1'b0; bus.in_a  = '0; bus.in_b  = '0; bus.out_ready  = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.out_ready = 1'b1;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_sum",   32'(bus.out_sum),   32'd0);
    check("rst_ser_ab",    32'({bus.ser_a, bus.ser_b}), 32'd0);
    check("rst_ser_clr",   32'(bus.ser_clr),   32'd1);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].sum, $sformatf("vec%0d", i));

    // Backpressure with competing operands offered during DONE.
    bus.out_ready = 1'b0;
    do_op(8'hC3, 8'h7E, 9'h141, "bp");
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = W'(i * 17 + 3);
      bus.in_b     = W'(i * 29 + 11);
      tick();
      check("bp_hold_sum",   32'(bus.out_sum),   32'h141);
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready",   32'(bus.in_ready),  32'd0);
    end
    bus.in_a      = 8'h12;
    bus.in_b      = 8'h34;
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    wait_out("bp_next");
    check("bp_next_sum", 32'(bus.out_sum), 32'h046);
    tick();

    // Asynchronous reset after three SHIFT cycles of 0xFF+0xFF.
    bus.in_valid = 1'b1;
    bus.in_a     = 8'hFF;
    bus.in_b     = 8'hFF;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_sum",   32'(bus.out_sum),   32'd0);
    sb_q.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    do_op(8'h01, 8'h01, 9'h002, "post_rst");

    // Back-to-back acceptances with in_valid held high.
    for (int i = 0; i < 4; i++) begin
      pa[i] = W'($urandom);
      pb[i] = W'($urandom);
    end
    acc_log.delete();
    out_base     = n_out;
    k            = 0;
    guard        = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = pa[0];
    bus.in_b     = pb[0];
    while (k < 4 && guard < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      guard++;
      if (acc) begin
        k++;
        if (k < 4) begin
          bus.in_a = pa[k];
          bus.in_b = pb[k];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.in_valid = 1'b0;
    check("b2b_accepts", 32'(k), 32'd4);
    wait_out("b2b_last");
    tick();
    check("b2b_outputs", 32'(n_out - out_base), 32'd4);
    check("b2b_acc_log", 32'(acc_log.size()), 32'd4);
    for (int i = 1; i < acc_log.size(); i++)
      check($sformatf("b2b_spacing%0d", i), 32'(acc_log[i] - acc_log[i-1]), 32'(W + 3));
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    // WIDTH=1 instance.
    for (int i = 0; i < 2; i++) begin
      bus1.in_valid = 1'b1;
      bus1.in_a     = vecs1[i].a;
      bus1.in_b     = vecs1[i].b;
      tick();
      bus1.in_valid = 1'b0;
      n = 0;
      while (!bus1.out_valid && n < 10) begin
        tick();
        n++;
      end
      check($sformatf("w1_latency%0d", i), 32'(n), 32'd2);
      check($sformatf("w1_sum%0d", i), 32'(bus1.out_sum), 32'(vecs1[i].sum));
      tick();
      check($sformatf("w1_in_ready%0d", i), 32'(bus1.in_ready), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_word_add_driver.md
# serial_word_add_driver

Word-level front end for the team's bit-serial adder. Accepts two WIDTH-bit operands over a valid/ready handshake and streams them LSB-first into an external serial adder. Collects the returned sum bits, including a final carry-flush bit, and presents a WIDTH+1-bit parallel result over a second valid/ready handshake. It is the parallel-side counterpart that feeds and drains the serial adder datapath.

## Interface
- WIDTH, 8, operand width in bits; legal range ≥1.

- clk  input  1  sole clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  driver can accept an operand pair.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- ser_clr  output  1  carry clear; drives the serial adder's synchronous rst.
- ser_a  output  1  serial bit of A to the adder.
- ser_b  output  1  serial bit of B to the adder.
- ser_sum  input  1  combinational sum bit returned by the adder.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  WIDTH+1  A+B; bit WIDTH is the carry out.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, ser_clr=1, ser_a=ser_b=0, out_valid=0.
  - On in_valid&in_ready: load shift_a←in_a, shift_b←in_b, bit counter←0, clear result register, go to SHIFT.
- SHIFT:
  - in_ready=0, ser_clr=0, ser_a=shift_a[0], ser_b=shift_b[0].
  - Each cycle: shift result register right by one, inserting ser_sum at bit WIDTH. Shift shift_a and shift_b right, filling with 0. Increment the counter.
  - Runs exactly WIDTH+1 cycles. The last cycle presents a=b=0, so ser_sum equals the adder carry, which lands in out_sum[WIDTH].
  - After the cycle with counter==WIDTH, go to DONE.
- DONE:
  - out_valid=1, out_sum holds the result, ser_clr=1, in_ready=0.
  - On out_ready: go to IDLE.
- Arithmetic: out_sum = zero-extended in_a + in_b, modulo 2^(WIDTH+1). Overflow is impossible.
- Carry is cleared through ser_clr in every cycle outside SHIFT. The adder's carry is therefore 0 at the first SHIFT cycle regardless of earlier history.
- No operation overlap: in_valid is ignored while not in IDLE. Operands are captured at acceptance; in_a/in_b may change afterwards.
- Counter width: $clog2(WIDTH+2).

## Timing
- Reset (async assert, any state): state=IDLE, counter=0, shift/result registers=0.
  - Outputs during and after reset: out_valid=0, out_sum=0, ser_a=ser_b=0, in_ready=1, ser_clr=1.
- Reset mid-SHIFT or mid-DONE: the in-flight operation is discarded with no out_valid pulse. ser_clr=1 in IDLE clears the adder carry before the next operation.
- Latency: the acceptance edge is E0; SHIFT occupies cycles E0+1 … E0+WIDTH+1; out_valid rises after edge E0+WIDTH+1.
- out_sum and out_valid are stable while out_valid&!out_ready (backpressure of any length).
- The output handshake completes at edge Ek; in_ready=1 in the following cycle.
- Minimum period between acceptances: WIDTH+3 cycles.
- ser_a/ser_b are registered (LSB of the shift registers). ser_sum is sampled in the same cycle its bits are driven; the combinational adder path is budgeted within one cycle.

## Test plan
All cases use WIDTH=8 unless noted.
- 0x5A + 0x3C → out_sum=0x096; out_valid asserted 9 cycles after acceptance; ser_a sequence LSB-first 0,1,0,1,1,0,1,0,0.
- 0xFF + 0x01 → 0x100; 0xFF + 0xFF → 0x1FE; 0x00 + 0x00 → 0x000. Checks carry ripple, the flush bit, and a zero carry.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while driving in_valid=1 with new operands. Required: out_sum held constant, in_ready=0, new operands not captured, and the next result is correct after release.
- Reset mid-operation: assert rst asynchronously after 3 SHIFT cycles of 0xFF+0xFF, then release. Required: immediately in_ready=1, out_valid=0, out_sum=0. A following 0x01+0x01 yields 0x002, with no stale carry.
- Back-to-back: in_valid held high with 4 random pairs and out_ready=1. Required: each result matches the reference sum, and acceptances are exactly WIDTH+3 cycles apart.
- WIDTH=1 instance: 1+1 → 0b10; 1+0 → 0b01.
